// File: rtl/fft_twiddle_addr_seq_pkg.sv
// Shared FFT definitions: default transform size, tag widths, sequencer
// state encoding and the packed twiddle-ROM stage base offset.
package fft_twiddle_addr_seq_pkg;

  localparam int N_LOG2_DEF = 5;
  localparam int ADDR_W_DEF = 5;
  localparam int STAGE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  // Stage s owns ROM words 2^s-1 .. 2^(s+1)-2 in the packed layout.
  function automatic int unsigned stage_base(input logic [STAGE_W-1:0] s);
    return (32'd1 << s) - 32'd1;
  endfunction

endpackage

// File: rtl/fft_twiddle_addr_seq.sv
// Twiddle address sequencer: walks every stage/butterfly of a radix-2 DIT FFT,
// addresses the registered twiddle ROMs and emits a tag aligned to ROM data.
module fft_twiddle_addr_seq
  import fft_twiddle_addr_seq_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 tw_valid,
  input  logic                 tw_ready,
  output logic [STAGE_W-1:0]   tw_stage,
  output logic [N_LOG2-2:0]    tw_bfly,
  output logic                 tw_last,
  output fsm_state_e           dbg_state
);

  // Handshake: a beat (ROM data + tag) transfers on a cycle where
  // tw_valid && tw_ready; once tw_valid rises it and the beat hold until then.

  localparam int                 BW         = N_LOG2 - 1;
  localparam logic [BW-1:0]      BFLY_LAST  = {BW{1'b1}};
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);

  fsm_state_e          state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [BW-1:0]       bfly_q, bfly_d;
  logic [ADDR_W-1:0]   iss_addr_q, iss_addr_d;
  logic                tw_valid_q, tw_valid_d;
  logic [STAGE_W-1:0]  tw_stage_q, tw_stage_d;
  logic [BW-1:0]       tw_bfly_q, tw_bfly_d;
  logic                tw_last_q, tw_last_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

  logic                stall;
  logic                iss_last;
  logic [ADDR_W-1:0]   base_d;

  assign stall    = tw_valid_q && !tw_ready;
  assign iss_last = (stage_q == STAGE_LAST) && (bfly_q == BFLY_LAST);

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    tw_valid_d = tw_valid_q;
    tw_stage_d = tw_stage_q;
    tw_bfly_d  = tw_bfly_q;
    tw_last_d  = tw_last_q;
    out_addr_d = out_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          tw_valid_d = 1'b1;
          tw_stage_d = stage_q;
          tw_bfly_d  = bfly_q;
          tw_last_d  = iss_last;
          out_addr_d = iss_addr_q;
          if (iss_last) begin
            state_d = ST_DRAIN;
          end else begin
            bfly_d = bfly_q + BW'(1);
            if (bfly_q == BFLY_LAST) stage_d = stage_q + STAGE_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (tw_valid_q && tw_ready) begin
          tw_valid_d = 1'b0;
          tw_last_d  = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
        bfly_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    // j mod 2^s is j masked by 2^s-1, which is the stage base itself.
    base_d     = ADDR_W'(stage_base(stage_d));
    iss_addr_d = base_d + (ADDR_W'(bfly_d) & base_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      bfly_q     <= '0;
      iss_addr_q <= '0;
      tw_valid_q <= 1'b0;
      tw_stage_q <= '0;
      tw_bfly_q  <= '0;
      tw_last_q  <= 1'b0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      bfly_q     <= bfly_d;
      iss_addr_q <= iss_addr_d;
      tw_valid_q <= tw_valid_d;
      tw_stage_q <= tw_stage_d;
      tw_bfly_q  <= tw_bfly_d;
      tw_last_q  <= tw_last_d;
      out_addr_q <= out_addr_d;
    end
  end

  // The ROMs read every cycle with no enable, so a stalled beat must re-present
  // its own address to keep data_out stable into the next cycle.
  assign rom_addr  = stall ? out_addr_q : iss_addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign tw_valid  = tw_valid_q;
  assign tw_stage  = tw_stage_q;
  assign tw_bfly   = tw_bfly_q;
  assign tw_last   = tw_last_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fft_twiddle_addr_seq.md
# fft_twiddle_addr_seq

Twiddle address sequencer for the radix-2 DIT FFT datapath. On a start pulse it walks every stage and butterfly of an N-point transform and drives the address of the twiddle ROM pair (real/imag, 1-cycle registered read). It also produces a valid/ready-qualified sideband (stage, butterfly index, last) aligned with the ROM data so the butterfly unit consumes twiddle and tag in the same cycle. It sits directly upstream of the twiddle ROMs and alongside the butterfly stage.

## Interface
- N_LOG2, 5: log2 of FFT length; stages = N_LOG2, butterflies per stage = 2^(N_LOG2-1)
- ADDR_W, 5: ROM address width; must satisfy 2^ADDR_W >= 2^N_LOG2 - 1
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a transform; accepted only when idle
- busy  out  1  high from accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse after the last beat is accepted
- rom_addr  out  ADDR_W  address to both twiddle ROMs
- tw_valid  out  1  ROM data_out and sideband valid this cycle
- tw_ready  in  1  butterfly unit accepts current twiddle
- tw_stage  out  3  stage index of current twiddle (0..N_LOG2-1)
- tw_bfly  out  N_LOG2-1  butterfly index within stage
- tw_last  out  1  high on final beat (last stage, last butterfly)

## Operation
- FSM: IDLE -> RUN on start; RUN -> DRAIN after last address issued; DRAIN -> DONE when last beat accepted; DONE -> IDLE unconditionally (done=1 in DONE).
- Counters: stage s (0..N_LOG2-1), butterfly j (0..2^(N_LOG2-1)-1); j increments per issued address, wraps to 0 and increments s.
- Packed ROM layout, decided: stage s occupies addresses 2^s-1 .. 2^(s+1)-2; rom_addr = (2^s - 1) + (j mod 2^s). For N_LOG2=5: stage0 addr 0; stage1 1-2; stage2 3-6; stage3 7-14; stage4 15-30; address 31 never issued.
- Two-slot pipeline: issue slot (rom_addr + tag) and output slot (tw_valid + tag, matches ROM output). Pipeline advances when !tw_valid || tw_ready.
- Stall: rom_addr and issue tag hold; the ROM re-reads the same address, so data_out stays stable while tw_valid && !tw_ready.
- start while busy: ignored. start in the DONE cycle: ignored.
- Total beats per transform: N_LOG2 * 2^(N_LOG2-1) (80 for default).

## Timing
- Reset values: busy 0, done 0, rom_addr 0, tw_valid 0, tw_stage 0, tw_bfly 0, tw_last 0; FSM IDLE, counters 0.
- start sampled at cycle T -> busy=1 and rom_addr = first address at T+1 -> tw_valid=1 at T+2 with ROM data for that address.
- With tw_ready held high: one beat per cycle, beats at T+2..T+81, tw_last at T+81, done at T+82, busy falls at T+83.
- tw_valid must not drop without a handshake; tag and ROM data change only after tw_valid && tw_ready.
- Reset mid-transform: all state returns to reset values asynchronously; no done pulse; next start begins a fresh transform at stage 0.
- Addition for the base address uses ADDR_W-bit unsigned arithmetic, without overflow by the parameter constraint.

## Structure
- Shared FFT package: N_LOG2 default, stage and butterfly widths, FSM state encoding, and the base-offset function 2^s-1.
- No sub-module; the FSM, counters and two-slot pipeline live in one module. ROMs are instantiated by the parent, not in this block.

## Test plan
- Reset then a single start with tw_ready=1 -> address sequence 0x16, 1,2×8, 3..6×4, 7..14×2, 15..30; 80 beats; tw_last on beat 80; done at T+82.
- tw_ready low for 3 cycles at stage2 bfly5 -> rom_addr holds 4, tw_valid stays high, tag (2,5) and ROM data stable, no beat lost or duplicated.
- start pulsed at cycles T+10 and T+82 -> both ignored, exactly 80 beats, one done.
- rst_n asserted at beat 40 -> all outputs 0 immediately; a later start yields a full 80-beat sequence from addr 0.
- Random tw_ready (50%) over 3 back-to-back transforms -> scoreboard matches the packed-address model, 240 beats, 3 done pulses.
- Back-to-back start asserted in the IDLE cycle after done -> new transform with first tw_valid two cycles after start.
